// File: rtl/bootram_ctrl_if.sv
// CPU native memory bus seen by the boot RAM controller: valid/ready handshake,
// byte-strobed writes and a registered read-data return.
interface bootram_ctrl_if;
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;

    modport master (output valid, addr, wdata, wstrb, input ready, rdata);
    modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/bootram_ctrl.sv
// Boot RAM controller: turns CPU bus accesses into strobes for four byte-lane RAMs
// with one-cycle read latency, and provides a sequential byte loader for preloading.
module bootram_ctrl #(
    parameter int AW = 11
) (
    input  logic              clk,
    input  logic              reset,
    bootram_ctrl_if.slave     mem_s,
    input  logic              ld_en,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [7:0]        ld_data,
    output logic [AW+1:0]     ld_count,
    output logic              ld_ovf,
    output logic [AW-1:0]     ram_ad,
    output logic [3:0]        ram_ce,
    output logic [3:0]        ram_wre,
    output logic              ram_oce,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RD_DONE = 3'd2,
        ST_WR_DONE = 3'd3,
        ST_LOAD    = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [AW+1:0]   ld_count_q, ld_count_d;
    logic            ld_ovf_q, ld_ovf_d;

    logic            ready_s;
    logic            ld_ready_s;
    logic [AW-1:0]   ram_ad_s;
    logic [3:0]      ram_ce_s;
    logic [3:0]      ram_wre_s;
    logic [31:0]     ram_din_s;
    logic            unused_addr_s;

    function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
        case (lane)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0010;
            2'd2:    return 4'b0100;
            2'd3:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    assign unused_addr_s = ^{mem_s.addr[31:AW+2], mem_s.addr[1:0]};

    // Next-state, RAM strobe and handshake decode
    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        ld_count_d = ld_count_q;
        ld_ovf_d   = ld_ovf_q;
        ready_s    = 1'b0;
        ld_ready_s = 1'b0;
        ram_ad_s   = {AW{1'b0}};
        ram_ce_s   = 4'b0000;
        ram_wre_s  = 4'b0000;
        ram_din_s  = 32'h0000_0000;
        case (state_q)
            ST_IDLE: begin
                // Loader entry wins over a bus request in the same cycle
                if (ld_en) begin
                    state_d    = ST_LOAD;
                    ld_count_d = {(AW+2){1'b0}};
                    ld_ovf_d   = 1'b0;
                end else if (mem_s.valid) begin
                    ram_ad_s = mem_s.addr[AW+1:2];
                    if (mem_s.wstrb == 4'b0000) begin
                        ram_ce_s = 4'hF;
                        state_d  = ST_RD_WAIT;
                    end else begin
                        ram_ce_s  = mem_s.wstrb;
                        ram_wre_s = mem_s.wstrb;
                        ram_din_s = mem_s.wdata;
                        state_d   = ST_WR_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                rdata_d = ram_dout;
                state_d = ST_RD_DONE;
            end
            ST_RD_DONE: begin
                ready_s = 1'b1;
                state_d = ST_IDLE;
            end
            ST_WR_DONE: begin
                ready_s = 1'b1;
                state_d = ST_IDLE;
            end
            ST_LOAD: begin
                if (ld_en) begin
                    ld_ready_s = 1'b1;
                    ram_ad_s   = ld_count_q[AW+1:2];
                    if (ld_valid) begin
                        ram_ce_s   = lane_onehot(ld_count_q[1:0]);
                        ram_wre_s  = lane_onehot(ld_count_q[1:0]);
                        ram_din_s  = {4{ld_data}};
                        ld_count_d = ld_count_q + {{(AW+1){1'b0}}, 1'b1};
                        ld_ovf_d   = ld_ovf_q | (&ld_count_q);
                    end else begin
                        ld_count_d = ld_count_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rdata_q    <= 32'h0000_0000;
            ld_count_q <= {(AW+2){1'b0}};
            ld_ovf_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            ld_count_q <= ld_count_d;
            ld_ovf_q   <= ld_ovf_d;
        end
    end

    // Reset must suppress any RAM write or handshake decoded in the same cycle
    assign mem_s.ready = reset ? 1'b0 : ready_s;
    assign mem_s.rdata = rdata_q;
    assign ld_ready    = reset ? 1'b0 : ld_ready_s;
    assign ld_count    = ld_count_q;
    assign ld_ovf      = ld_ovf_q;
    assign ram_ad      = reset ? {AW{1'b0}} : ram_ad_s;
    assign ram_ce      = reset ? 4'b0000 : ram_ce_s;
    assign ram_wre     = reset ? 4'b0000 : ram_wre_s;
    assign ram_din     = reset ? 32'h0000_0000 : ram_din_s;
    assign ram_oce     = 1'b1;

endmodule

// File: tb/tb_bootram_ctrl.sv
// Directed bench for bootram_ctrl with a behavioural model of the four byte-lane RAMs.
module tb_bootram_ctrl;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic          ld_en, ld_valid, ld_ready, ld_ovf, ram_oce;
    logic [7:0]    ld_data;
    logic [AW+1:0] ld_count;
    logic [AW-1:0] ram_ad;
    logic [3:0]    ram_ce, ram_wre;
    logic [31:0]   ram_din, ram_dout;
    logic [7:0]    ram_mem [4][2048];
    int            checks = 0;
    int            errors = 0;

    bootram_ctrl_if bus ();

    bootram_ctrl #(.AW(AW)) dut (
        .clk(clk), .reset(reset), .mem_s(bus),
        .ld_en(ld_en), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .ld_count(ld_count), .ld_ovf(ld_ovf),
        .ram_ad(ram_ad), .ram_ce(ram_ce), .ram_wre(ram_wre), .ram_oce(ram_oce),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Byte-lane RAMs: write on ce&wre, otherwise registered read on ce
    always @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (ram_ce[n]) begin
                if (ram_wre[n]) ram_mem[n][ram_ad] <= ram_din[8*n +: 8];
                else            ram_dout[8*n +: 8] <= ram_mem[n][ram_ad];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.valid = 1'b1; bus.addr = a; bus.wdata = d; bus.wstrb = s;
        #1;
        chk("wr_ce", {28'h0, ram_ce}, {28'h0, s});
        chk("wr_ready_t0", {31'h0, bus.ready}, 32'h0);
        tick();
        bus.valid = 1'b0;
        #1;
        chk("wr_ready_t1", {31'h0, bus.ready}, 32'h1);
        tick();
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
        bus.valid = 1'b1; bus.addr = a; bus.wstrb = 4'h0;
        #1;
        chk("rd_ce", {28'h0, ram_ce}, 32'h0000_000F);
        tick();
        bus.valid = 1'b0;
        #1;
        chk("rd_ready_t1", {31'h0, bus.ready}, 32'h0);
        tick();
        chk("rd_ready_t2", {31'h0, bus.ready}, 32'h1);
        chk(tag, bus.rdata, exp);
        tick();
    endtask

    initial begin
        reset = 1'b1; ld_en = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
        bus.valid = 1'b1; bus.addr = 32'h0000_0044; bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 4'hF;
        tick();
        tick();
        chk("rst_ready", {31'h0, bus.ready}, 32'h0);
        chk("rst_ce", {28'h0, ram_ce}, 32'h0);
        chk("rst_wre", {28'h0, ram_wre}, 32'h0);
        chk("rst_ad", {21'h0, ram_ad}, 32'h0);
        chk("rst_din", ram_din, 32'h0);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_ld_count", {19'h0, ld_count}, 32'h0);
        chk("rst_ld_ovf", {31'h0, ld_ovf}, 32'h0);
        chk("rst_ld_ready", {31'h0, ld_ready}, 32'h0);
        chk("oce", {31'h0, ram_oce}, 32'h1);
        bus.valid = 1'b0;
        reset = 1'b0;
        tick();

        // Full word write and readback
        bus_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        bus_read(32'h0000_0010, 32'hDEAD_BEEF, "rd_deadbeef");

        // Single-lane partial write
        bus_write(32'h0000_0014, 32'h1122_3344, 4'hF);
        bus.valid = 1'b1; bus.addr = 32'h0000_0014; bus.wdata = 32'h00AA_0000; bus.wstrb = 4'b0100;
        #1;
        chk("pw_ce", {28'h0, ram_ce}, 32'h0000_0004);
        chk("pw_wre", {28'h0, ram_wre}, 32'h0000_0004);
        chk("pw_ad", {21'h0, ram_ad}, 32'h0000_0005);
        tick();
        bus.valid = 1'b0;
        #1;
        chk("pw_ready", {31'h0, bus.ready}, 32'h1);
        tick();
        bus_read(32'h0000_0014, 32'h11AA_3344, "rd_partial");

        // Loader: eight bytes into words 0 and 1
        ld_en = 1'b1;
        #1;
        chk("ld_idle_ready", {31'h0, ld_ready}, 32'h0);
        tick();
        for (int i = 0; i < 8; i++) begin
            ld_valid = 1'b1; ld_data = 8'(i + 1);
            #1;
            chk("ld_ready", {31'h0, ld_ready}, 32'h1);
            chk("ld_ce", {28'h0, ram_ce}, 32'(4'b0001 << (i % 4)));
            chk("ld_din", ram_din, {4{8'(i + 1)}});
            tick();
        end
        ld_valid = 1'b0; ld_en = 1'b0;
        #1;
        chk("ld_exit_ready", {31'h0, ld_ready}, 32'h0);
        chk("ld_exit_ce", {28'h0, ram_ce}, 32'h0);
        tick();
        chk("ld_count8", {19'h0, ld_count}, 32'h8);
        chk("ld_ovf8", {31'h0, ld_ovf}, 32'h0);
        bus_read(32'h0000_0000, 32'h0403_0201, "rd_ld_w0");
        bus_read(32'h0000_0004, 32'h0807_0605, "rd_ld_w1");

        // Loader entry wins over a simultaneous read
        ld_en = 1'b1; bus.valid = 1'b1; bus.addr = 32'h0000_0010; bus.wstrb = 4'h0;
        #1;
        chk("prio_ce", {28'h0, ram_ce}, 32'h0);
        tick();
        ld_en = 1'b0;
        #1;
        chk("prio_ready_load", {31'h0, bus.ready}, 32'h0);
        chk("prio_ld_ready", {31'h0, ld_ready}, 32'h0);
        tick();
        chk("prio_ce_idle", {28'h0, ram_ce}, 32'h0000_000F);
        chk("prio_ready_idle", {31'h0, bus.ready}, 32'h0);
        tick();
        bus.valid = 1'b0;
        #1;
        chk("prio_ready_wait", {31'h0, bus.ready}, 32'h0);
        tick();
        chk("prio_ready_done", {31'h0, bus.ready}, 32'h1);
        chk("prio_rdata", bus.rdata, 32'hDEAD_BEEF);
        tick();

        // Reset during RD_WAIT aborts the read
        bus.valid = 1'b1; bus.addr = 32'h0000_0014; bus.wstrb = 4'h0;
        tick();
        bus.valid = 1'b0; reset = 1'b1;
        #1;
        chk("abort_ready_rst", {31'h0, bus.ready}, 32'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("abort_ready", {31'h0, bus.ready}, 32'h0);
        chk("abort_rdata", bus.rdata, 32'h0);
        tick();
        chk("abort_ready_next", {31'h0, bus.ready}, 32'h0);
        bus_read(32'h0000_0014, 32'h11AA_3344, "rd_after_abort");

        // Write presented during reset is suppressed
        reset = 1'b1; bus.valid = 1'b1; bus.addr = 32'h0000_0014;
        bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 4'hF;
        #1;
        chk("rst_wr_wre", {28'h0, ram_wre}, 32'h0);
        tick();
        reset = 1'b0; bus.valid = 1'b0;
        tick();
        bus_read(32'h0000_0014, 32'h11AA_3344, "rd_rst_write");

        // Loader wrap: 8193 bytes
        ld_en = 1'b1;
        tick();
        for (int i = 0; i < 8193; i++) begin
            ld_valid = 1'b1;
            ld_data  = (i == 8192) ? 8'hC3 : 8'(i);
            if (i == 8192) begin
                #1;
                chk("wrap_count0", {19'h0, ld_count}, 32'h0);
                chk("wrap_ovf_set", {31'h0, ld_ovf}, 32'h1);
                chk("wrap_ce", {28'h0, ram_ce}, 32'h1);
                chk("wrap_ad", {21'h0, ram_ad}, 32'h0);
            end else begin
                #1;
            end
            tick();
        end
        ld_valid = 1'b0; ld_en = 1'b0;
        tick();
        chk("wrap_count1", {19'h0, ld_count}, 32'h1);
        chk("wrap_ovf", {31'h0, ld_ovf}, 32'h1);
        bus_read(32'h0000_0000, 32'h0302_01C3, "rd_wrap_w0");
        bus_read(32'h0000_0004, 32'h0706_0504, "rd_wrap_w1");
        chk("wrap_ovf_hold", {31'h0, ld_ovf}, 32'h1);

        // Re-entry clears the overflow flag and count
        ld_en = 1'b1;
        tick();
        chk("reentry_ovf", {31'h0, ld_ovf}, 32'h0);
        chk("reentry_count", {19'h0, ld_count}, 32'h0);
        ld_en = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
